alu_ctrl_seq: RTL and testbench
===============================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 4, giving the ALU control word width (min 3).
REQ-002 The block SHALL have parameter NOP_CODE, default 4'b0000, giving the idle control word.
REQ-003 The block SHALL have parameter MOV_CODE, default 4'b0001, giving the internal MOV control word.
REQ-004 The block SHALL have parameter INC_CODE, default 4'b0010, giving the internal increment control word.
REQ-005 The block SHALL have parameter DEC_CODE, default 4'b0011, giving the internal decrement control word.
REQ-006 The block SHALL have parameter ADDR_CODE, default 4'b0100, giving the address-calculation control word.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 req  input  1  operation request, active-high.
REQ-010 ctrl_in  input  CTRL_W  instruction-level ALU control word for normal mode.
REQ-011 internal_mov_n  input  1  active-low: internal operation selected.
REQ-012 address_mode_n  input  1  active-low: prepend an address-calculation step.
REQ-013 internal_inc_dec_n  input  1  active-low: internal op is INC/DEC rather than MOV.
REQ-014 internal_dec_n  input  1  active-low: INC/DEC op is DEC.
REQ-015 stall  input  1  active-high: freeze the current step.
REQ-016 ctrl_out  output  CTRL_W  registered ALU control word.
REQ-017 busy  output  1  registered; high while state is not IDLE.
REQ-018 done  output  1  registered; single-cycle pulse on sequence completion.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, ADDR and EXEC.
REQ-020 A request SHALL be accepted only on an edge where state=IDLE and req=1; req in ADDR/EXEC SHALL be ignored, with no queueing.
REQ-021 Mode inputs and ctrl_in SHALL be sampled only at acceptance and held internally for the whole sequence.
REQ-022 The op code SHALL decode with the following priority: internal_mov_n=1 gives ctrl_in; else internal_inc_dec_n=1 gives MOV_CODE; else internal_dec_n=1 gives INC_CODE; else DEC_CODE.
REQ-023 On acceptance with address_mode_n=0, the block SHALL go to ADDR with ctrl_out<=ADDR_CODE.
REQ-024 On acceptance with address_mode_n=1, the block SHALL go to EXEC with ctrl_out<=op code.
REQ-025 In ADDR with stall=0, the next state SHALL be EXEC with ctrl_out<=held op code.
REQ-026 In EXEC with stall=0, the next state SHALL be IDLE, with ctrl_out<=NOP_CODE and done<=1.
REQ-027 With stall=1 in ADDR or EXEC, state and ctrl_out SHALL hold, and done SHALL remain 0.
REQ-028 In IDLE, stall SHALL have no effect.
REQ-029 done SHALL be 1 for exactly one cycle per sequence; on all other edges done<=0.
REQ-030 Latency SHALL be as follows: the first step code appears the cycle after acceptance; normal sequences take 1 step and address-mode sequences take 2 steps.
REQ-031 req asserted in the cycle done=1 (state=IDLE) SHALL be accepted, giving back-to-back issue every 2 cycles (normal) or every 3 cycles (address mode).
REQ-032 ctrl_out SHALL equal NOP_CODE whenever state=IDLE.
REQ-033 All codes and ctrl_in SHALL be exactly CTRL_W bits, with no truncation or extension.
REQ-034 internal_inc_dec_n and internal_dec_n SHALL be don't-care when internal_mov_n=1.

Reset
REQ-035 rst_n=0 SHALL, asynchronously, set state=IDLE, ctrl_out=NOP_CODE, busy=0, done=0, and clear held op/mode.
REQ-036 Reset asserted mid-sequence SHALL abort the sequence with no done pulse; the first request after rst_n rises SHALL be accepted normally.

Verification (CTRL_W=4, default codes)
REQ-037 Normal: req=1, internal_mov_n=1, address_mode_n=1, ctrl_in=1010 -> ctrl_out=1010 and busy=1 next cycle, then ctrl_out=0000 with done=1.
REQ-038 Address+DEC: internal_mov_n=0, address_mode_n=0, internal_inc_dec_n=0, internal_dec_n=0 -> ctrl_out sequence 0100, 0011, 0000; done=1 in the third cycle only.
REQ-039 Stall: address+INC with stall=1 for 2 cycles during ADDR -> ctrl_out=0100 held for 3 cycles, then 0010, then 0000 with done.
REQ-040 Ignored req and input change: req=1 held continuously while mode inputs change during EXEC -> held op unaffected; next acceptance occurs in the done cycle.
REQ-041 Reset mid-op: rst_n=0 during ADDR -> ctrl_out=0000 and busy=0 immediately (without a clock); done never pulses.
REQ-042 Mode priority: internal_mov_n=0, internal_inc_dec_n=1, internal_dec_n=0 -> ctrl_out=0001 (MOV).

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: issues an optional address-calculation step followed by one
// execute step per accepted request, then returns to idle with a single-cycle done pulse.
module alu_ctrl_seq #(
  parameter int unsigned          CTRL_W    = 4,
  parameter logic [CTRL_W-1:0]    NOP_CODE  = 4'b0000,
  parameter logic [CTRL_W-1:0]    MOV_CODE  = 4'b0001,
  parameter logic [CTRL_W-1:0]    INC_CODE  = 4'b0010,
  parameter logic [CTRL_W-1:0]    DEC_CODE  = 4'b0011,
  parameter logic [CTRL_W-1:0]    ADDR_CODE = 4'b0100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              internal_mov_n,
  input  logic              address_mode_n,
  input  logic              internal_inc_dec_n,
  input  logic              internal_dec_n,
  input  logic              stall,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StExec = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CTRL_W-1:0] op_q, op_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CTRL_W-1:0] op_dec;

  // Priority decode of the mode inputs; inc/dec selects are ignored in normal mode.
  always_comb begin
    if (internal_mov_n) begin
      op_dec = ctrl_in;
    end else if (internal_inc_dec_n) begin
      op_dec = MOV_CODE;
    end else if (internal_dec_n) begin
      op_dec = INC_CODE;
    end else begin
      op_dec = DEC_CODE;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    op_d    = op_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ctrl_d = NOP_CODE;
        if (req) begin
          op_d = op_dec;
          if (!address_mode_n) begin
            state_d = StAddr;
            ctrl_d  = ADDR_CODE;
          end else begin
            state_d = StExec;
            ctrl_d  = op_dec;
          end
        end
      end
      StAddr: begin
        if (!stall) begin
          state_d = StExec;
          ctrl_d  = op_q;
        end
      end
      StExec: begin
        if (!stall) begin
          state_d = StIdle;
          ctrl_d  = NOP_CODE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        ctrl_d  = NOP_CODE;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ctrl_q  <= NOP_CODE;
      op_q    <= NOP_CODE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ctrl_out = ctrl_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: each cycle's expected outputs are queued as the
// stimulus is applied and popped for comparison one time unit after the clock edge.
module tb_alu_ctrl_seq;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [3:0] ctrl_in;
  logic       internal_mov_n;
  logic       address_mode_n;
  logic       internal_inc_dec_n;
  logic       internal_dec_n;
  logic       stall;
  logic [3:0] ctrl_out;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic       req;
    logic       mov_n;
    logic       addr_n;
    logic       incdec_n;
    logic       dec_n;
    logic       stall;
    logic [3:0] ctrl;
  } stim_t;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  alu_ctrl_seq dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req                (req),
    .ctrl_in            (ctrl_in),
    .internal_mov_n     (internal_mov_n),
    .address_mode_n     (address_mode_n),
    .internal_inc_dec_n (internal_inc_dec_n),
    .internal_dec_n     (internal_dec_n),
    .stall              (stall),
    .ctrl_out           (ctrl_out),
    .busy               (busy),
    .done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input stim_t s);
    req                = s.req;
    internal_mov_n     = s.mov_n;
    address_mode_n     = s.addr_n;
    internal_inc_dec_n = s.incdec_n;
    internal_dec_n     = s.dec_n;
    stall              = s.stall;
    ctrl_in            = s.ctrl;
  endtask

  task automatic push(input logic [3:0] c, input logic b, input logic d);
    exp_t e;
    e.ctrl = c;
    e.busy = b;
    e.done = d;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    apply(stim_t'{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1010});
    push(4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    e = sb.pop_front();
    n_cmp++;
    if ({ctrl_out, busy, done} !== {e.ctrl, e.busy, e.done}) begin
      n_err++;
      $display("FAIL reset: got ctrl=%b busy=%b done=%b want ctrl=%b busy=%b done=%b",
               ctrl_out, busy, done, e.ctrl, e.busy, e.done);
    end
    rst_n = 1'b1;
    apply(stim_t'{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000});
    tick();
  endtask

  task automatic test_normal();
    stim_t st[3];
    exp_t  ex[3];
    exp_t  e;
    st = '{stim_t'{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010},
           stim_t'{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101},
           stim_t'{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101}};
    ex = '{exp_t'{4'b1010, 1'b1, 1'b0},
           exp_t'{4'b0000, 1'b0, 1'b1},
           exp_t'{4'b0000, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({ctrl_out, busy, done} !== {e.ctrl, e.busy, e.done}) begin
        n_err++;
        $display("FAIL normal[%0d]: got ctrl=%b busy=%b done=%b want ctrl=%b busy=%b done=%b",
                 i, ctrl_out, busy, done, e.ctrl, e.busy, e.done);
      end
    end
  endtask

  task automatic test_addr_dec();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  e;
    st = '{stim_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111},
           stim_t'{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111},
           stim_t'{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111},
           stim_t'{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111}};
    ex = '{exp_t'{4'b0100, 1'b1, 1'b0},
           exp_t'{4'b0011, 1'b1, 1'b0},
           exp_t'{4'b0000, 1'b0, 1'b1},
           exp_t'{4'b0000, 1'b0, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({ctrl_out, busy, done} !== {e.ctrl, e.busy, e.done}) begin
        n_err++;
        $display("FAIL addr_dec[%0d]: got ctrl=%b busy=%b done=%b want ctrl=%b busy=%b done=%b",
                 i, ctrl_out, busy, done, e.ctrl, e.busy, e.done);
      end
    end
  endtask

  task automatic test_stall();
    stim_t st[6];
    exp_t  ex[6];
    exp_t  e;
    st = '{stim_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000},
           stim_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000},
           stim_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000},
           stim_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000},
           stim_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000},
           stim_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000}};
    ex = '{exp_t'{4'b0100, 1'b1, 1'b0},
           exp_t'{4'b0100, 1'b1, 1'b0},
           exp_t'{4'b0100, 1'b1, 1'b0},
           exp_t'{4'b0010, 1'b1, 1'b0},
           exp_t'{4'b0000, 1'b0, 1'b1},
           exp_t'{4'b0000, 1'b0, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({ctrl_out, busy, done} !== {e.ctrl, e.busy, e.done}) begin
        n_err++;
        $display("FAIL stall[%0d]: got ctrl=%b busy=%b done=%b want ctrl=%b busy=%b done=%b",
                 i, ctrl_out, busy, done, e.ctrl, e.busy, e.done);
      end
    end
  endtask

  // req held high throughout; mode inputs change while the held op is executing.
  task automatic test_back_to_back();
    stim_t st[8];
    exp_t  ex[8];
    exp_t  e;
    st = '{stim_t'{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1010},
           stim_t'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110},
           stim_t'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110},
           stim_t'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110},
           stim_t'{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111},
           stim_t'{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111},
           stim_t'{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1001},
           stim_t'{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1001}};
    ex = '{exp_t'{4'b0100, 1'b1, 1'b0},
           exp_t'{4'b1010, 1'b1, 1'b0},
           exp_t'{4'b0000, 1'b0, 1'b1},
           exp_t'{4'b0011, 1'b1, 1'b0},
           exp_t'{4'b0000, 1'b0, 1'b1},
           exp_t'{4'b1111, 1'b1, 1'b0},
           exp_t'{4'b0000, 1'b0, 1'b1},
           exp_t'{4'b0000, 1'b0, 1'b0}};
    for (int i = 0; i < 8; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({ctrl_out, busy, done} !== {e.ctrl, e.busy, e.done}) begin
        n_err++;
        $display("FAIL b2b[%0d]: got ctrl=%b busy=%b done=%b want ctrl=%b busy=%b done=%b",
                 i, ctrl_out, busy, done, e.ctrl, e.busy, e.done);
      end
    end
  endtask

  // Also checks that stall in IDLE does not block acceptance, and stall in EXEC holds.
  task automatic test_priority();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  e;
    st = '{stim_t'{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1110},
           stim_t'{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1110},
           stim_t'{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1110},
           stim_t'{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1110}};
    ex = '{exp_t'{4'b0001, 1'b1, 1'b0},
           exp_t'{4'b0001, 1'b1, 1'b0},
           exp_t'{4'b0000, 1'b0, 1'b1},
           exp_t'{4'b0000, 1'b0, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({ctrl_out, busy, done} !== {e.ctrl, e.busy, e.done}) begin
        n_err++;
        $display("FAIL priority[%0d]: got ctrl=%b busy=%b done=%b want ctrl=%b busy=%b done=%b",
                 i, ctrl_out, busy, done, e.ctrl, e.busy, e.done);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t st[6];
    exp_t  ex[6];
    exp_t  e;
    st = '{stim_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000},
           stim_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000},
           stim_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000},
           stim_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000},
           stim_t'{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100},
           stim_t'{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100}};
    // Entries 1..3 are checked while reset is held or just after release.
    ex = '{exp_t'{4'b0100, 1'b1, 1'b0},
           exp_t'{4'b0000, 1'b0, 1'b0},
           exp_t'{4'b0000, 1'b0, 1'b0},
           exp_t'{4'b0000, 1'b0, 1'b0},
           exp_t'{4'b1100, 1'b1, 1'b0},
           exp_t'{4'b0000, 1'b0, 1'b1}};
    for (int i = 0; i < 6; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      if (i == 1) begin
        #2;
        rst_n = 1'b0;
        #1;
      end else begin
        tick();
      end
      if (i == 3) rst_n = 1'b1;
      e = sb.pop_front();
      n_cmp++;
      if ({ctrl_out, busy, done} !== {e.ctrl, e.busy, e.done}) begin
        n_err++;
        $display("FAIL reset_mid[%0d]: got ctrl=%b busy=%b done=%b want ctrl=%b busy=%b done=%b",
                 i, ctrl_out, busy, done, e.ctrl, e.busy, e.done);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_normal();
    test_addr_dec();
    test_stall();
    test_back_to_back();
    test_priority();
    test_reset_mid();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
